// File: rtl/bin_search_histogram_if.sv
// Bus bundle for bin_search_histogram: sample strobe/config, result flags and
// the histogram read port. Clock and reset stay outside.
interface bin_search_histogram_if #(
    parameter int VAL_W = 32,
    parameter int IDX_W = 6,
    parameter int BW_W  = 16,
    parameter int CNT_W = 16
);
    logic                    data_in;
    logic signed [VAL_W-1:0] value;
    logic [IDX_W-1:0]        num_bins;
    logic [BW_W-1:0]         bin_width;
    logic signed [BW_W-1:0]  origin;
    logic                    busy;
    logic                    binned;
    logic [IDX_W-1:0]        current;
    logic                    out_of_range;
    logic                    dropped;
    logic                    clear;
    logic [IDX_W-1:0]        rd_addr;
    logic [CNT_W-1:0]        rd_data;
    logic [CNT_W-1:0]        under_cnt;
    logic [CNT_W-1:0]        over_cnt;

    modport master (
        output data_in, value, num_bins, bin_width, origin, clear, rd_addr,
        input  busy, binned, current, out_of_range, dropped, rd_data, under_cnt, over_cnt
    );

    modport slave (
        input  data_in, value, num_bins, bin_width, origin, clear, rd_addr,
        output busy, binned, current, out_of_range, dropped, rd_data, under_cnt, over_cnt
    );
endinterface

// File: rtl/bin_search_histogram.sv
// Histogram engine: classifies a signed sample into uniform bins with a
// fixed-latency binary search over bin edges and keeps saturating per-bin counts.
module bin_search_histogram #(
    parameter int VAL_W = 32,
    parameter int IDX_W = 6,
    parameter int BW_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk100,
    input  logic                    rst_n,
    bin_search_histogram_if.slave   bus
);
    localparam int NB = 1 << IDX_W;
    localparam int EW = VAL_W + BW_W + IDX_W + 2;
    localparam int SW = (IDX_W > 1) ? $clog2(IDX_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RANGE, S_SEARCH, S_UPDATE} state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic signed [VAL_W-1:0] r_value;
    logic [IDX_W-1:0]        r_nb;
    logic [BW_W-1:0]         r_bw;
    logic signed [BW_W-1:0]  r_org;

    logic                    r_under;
    logic                    r_over;
    logic [IDX_W-1:0]        r_lo;
    logic [IDX_W-1:0]        r_hi;
    logic [SW-1:0]           r_step;

    logic                    r_binned;
    logic                    r_dropped;
    logic                    r_oor;
    logic [IDX_W-1:0]        r_current;

    logic [CNT_W-1:0]        r_cnt [NB];
    logic [CNT_W-1:0]        r_under_cnt;
    logic [CNT_W-1:0]        r_over_cnt;
    logic [CNT_W-1:0]        r_rd_data;

    logic signed [EW-1:0]    w_val;
    logic signed [EW-1:0]    w_org_edge;
    logic signed [EW-1:0]    w_top_edge;
    logic signed [EW-1:0]    w_mid_edge;
    logic [IDX_W:0]          w_sum;
    logic [IDX_W-1:0]        w_mid;
    logic                    w_gap;
    logic                    w_bad_cfg;
    logic                    w_busy;

    // Lower edge of bin k, computed wide enough that no term can overflow.
    function automatic logic signed [EW-1:0] edge_at(input logic [IDX_W-1:0] k,
                                                     input logic [BW_W-1:0] bw,
                                                     input logic signed [BW_W-1:0] org);
        logic signed [EW-1:0] w_k;
        logic signed [EW-1:0] w_bw;
        logic signed [EW-1:0] w_o;
        w_k  = $signed({{(EW-IDX_W){1'b0}}, k});
        w_bw = $signed({{(EW-BW_W){1'b0}}, bw});
        w_o  = EW'(org);
        return w_o + w_k * w_bw;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_val      = EW'(r_value);
    assign w_org_edge = edge_at('0, r_bw, r_org);
    assign w_top_edge = edge_at(r_nb, r_bw, r_org);
    assign w_sum      = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid      = IDX_W'(w_sum >> 1);
    assign w_mid_edge = edge_at(w_mid, r_bw, r_org);
    assign w_gap      = (r_hi - r_lo) > IDX_W'(1);
    assign w_bad_cfg  = (r_nb == '0) || (r_bw == '0);

    // FSM state register
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.data_in) w_next = S_RANGE;
            S_RANGE:  w_next = S_SEARCH;
            S_SEARCH: if (r_step == SW'(IDX_W - 1)) w_next = S_UPDATE;
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // Sample/config capture; data only, no reset needed
    always_ff @(posedge clk100) begin
        if (r_state == S_IDLE && bus.data_in) begin
            r_value <= bus.value;
            r_nb    <= bus.num_bins;
            r_bw    <= bus.bin_width;
            r_org   <= bus.origin;
        end
    end

    // Range check, search iteration and result flags
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_under   <= 1'b0;
            r_over    <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_step    <= '0;
            r_binned  <= 1'b0;
            r_dropped <= 1'b0;
            r_oor     <= 1'b0;
            r_current <= '0;
        end else begin
            r_binned  <= 1'b0;
            r_dropped <= w_busy && bus.data_in;
            case (r_state)
                S_RANGE: begin
                    r_over  <= w_bad_cfg || (w_val >= w_top_edge);
                    r_under <= !w_bad_cfg && (w_val < w_org_edge);
                    r_lo    <= '0;
                    r_hi    <= r_nb;
                    r_step  <= '0;
                end
                S_SEARCH: begin
                    r_step <= r_step + SW'(1);
                    if (w_gap) begin
                        if (w_val >= w_mid_edge) r_lo <= w_mid;
                        else                     r_hi <= w_mid;
                    end
                end
                S_UPDATE: begin
                    r_binned <= 1'b1;
                    r_oor    <= r_under || r_over;
                    if (!(r_under || r_over)) r_current <= r_lo;
                end
                default: ;
            endcase
        end
    end

    // Counter bank; clear takes priority over the update increment
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
            r_under_cnt <= '0;
            r_over_cnt  <= '0;
            r_rd_data   <= '0;
        end else begin
            r_rd_data <= r_cnt[bus.rd_addr];
            if (bus.clear) begin
                for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
                r_under_cnt <= '0;
                r_over_cnt  <= '0;
            end else if (r_state == S_UPDATE) begin
                if (r_under)     r_under_cnt <= sat_inc(r_under_cnt);
                else if (r_over) r_over_cnt  <= sat_inc(r_over_cnt);
                else             r_cnt[r_lo] <= sat_inc(r_cnt[r_lo]);
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.binned       = r_binned;
    assign bus.current      = r_current;
    assign bus.out_of_range = r_oor;
    assign bus.dropped      = r_dropped;
    assign bus.rd_data      = r_rd_data;
    assign bus.under_cnt    = r_under_cnt;
    assign bus.over_cnt     = r_over_cnt;
endmodule
